// File: rtl/tlc_timing_pkg.sv
// rtl/tlc_timing_pkg.sv - shared thresholds and encodings for the traffic-light controller and its timer
package tlc_timing_pkg;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_PRESCALE = 50;
  localparam int DEF_T_RED    = 30;
  localparam int DEF_T_GREEN  = 90;
  localparam int DEF_T_YEL    = 100;

  typedef enum logic [3:0] {
    SIDE_N = 4'b0001,
    SIDE_E = 4'b0010,
    SIDE_S = 4'b0100,
    SIDE_W = 4'b1000
  } side_t;

  typedef enum logic [1:0] {
    CTL_RED    = 2'd0,
    CTL_GREEN  = 2'd1,
    CTL_YELLOW = 2'd2
  } ctl_state_t;

  // A prescaler of 1 still needs a one-bit register.
  function automatic int presc_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/traffic_phase_timer_tick_gen.sv
// rtl/traffic_phase_timer_tick_gen.sv - prescaler producing one tick every PRESCALE clocks
module tick_gen
  import tlc_timing_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int              PW   = presc_width(PRESCALE);
  localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;

  assign tick = !clr && !hold && (presc == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (!hold) begin
      presc <= (presc == LAST) ? '0 : presc + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_phase_timer.sv
// rtl/traffic_phase_timer.sv - saturating tick counter with threshold flags and sticky timeout
module traffic_phase_timer
  import tlc_timing_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int T_RED    = DEF_T_RED,
  parameter int T_GREEN  = DEF_T_GREEN,
  parameter int T_YEL    = DEF_T_YEL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             hold,
  output logic [CNT_W-1:0] count,
  output logic             count_eq30,
  output logic             count_eq90,
  output logic             count_eq100,
  output logic             count_g_100,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_PRE = {{(CNT_W-1){1'b1}}, 1'b0};

  logic tick;

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clr  (clear),
    .hold (hold),
    .tick (tick)
  );

  // tick already excludes clear and hold, so only clear needs priority here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      timeout <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      timeout <= 1'b0;
    end else if (tick && (count != CNT_MAX)) begin
      count <= count + 1'b1;
      if (count == CNT_PRE) timeout <= 1'b1;
    end
  end

  // Decodes look only at the count register so the controller sees stable levels.
  assign count_eq30  = (count == CNT_W'(T_RED));
  assign count_eq90  = (count == CNT_W'(T_GREEN));
  assign count_eq100 = (count == CNT_W'(T_YEL));
  assign count_g_100 = (count >  CNT_W'(T_YEL));

endmodule

// File: tb/tb_traffic_phase_timer.sv
// tb/tb_traffic_phase_timer.sv - directed self-checking bench for traffic_phase_timer
module tb_traffic_phase_timer;
  import tlc_timing_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       clear_drv;
  logic       hold;
  logic       loop_en;
  logic [7:0] count;
  logic       count_eq30, count_eq90, count_eq100, count_g_100, timeout;

  int checks = 0;
  int errors = 0;

  ctl_state_t ctl_st;
  logic [1:0] side;
  int         rotations;
  logic       ctl_clear;

  always #5 clk = ~clk;

  traffic_phase_timer #(
    .CNT_W   (8),
    .PRESCALE(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .hold       (hold),
    .count      (count),
    .count_eq30 (count_eq30),
    .count_eq90 (count_eq90),
    .count_eq100(count_eq100),
    .count_g_100(count_g_100),
    .timeout    (timeout)
  );

  // Minimal controller used for the closed-loop rotation.
  assign ctl_clear = loop_en && (ctl_st == CTL_RED) && count_g_100;
  assign clear     = clear_drv | ctl_clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctl_st    <= CTL_RED;
      side      <= 2'd0;
      rotations <= 0;
    end else begin
      case (ctl_st)
        CTL_RED:    if (count_eq30)  ctl_st <= CTL_GREEN;
        CTL_GREEN:  if (count_eq90)  ctl_st <= CTL_YELLOW;
        CTL_YELLOW: if (count_eq100) ctl_st <= CTL_RED;
        default:    ctl_st <= CTL_RED;
      endcase
      if (ctl_clear) begin
        side      <= side + 2'd1;
        rotations <= rotations + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("eq_exclusive", 32'($countones({count_eq30, count_eq90, count_eq100}) <= 1), 32'd1);
    end
  endtask

  initial begin
    reset = 1'b0; clear_drv = 1'b0; hold = 1'b0; loop_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_count", count, 0);
    chk("rst_flags", {count_eq30, count_eq90, count_eq100, count_g_100}, 0);
    chk("rst_timeout", timeout, 0);
    reset = 1'b1;

    // 1: first tick at clk 4, count 30 at clk 120 for exactly 4 clks
    advance(3);   chk("c3_count", count, 0);
    advance(1);   chk("c4_count", count, 1);
    advance(115); chk("c119_count", count, 29); chk("c119_eq30", count_eq30, 0);
    for (int i = 0; i < 4; i++) begin
      advance(1);
      chk("eq30_level", count_eq30, 1);
      chk("eq30_count", count, 30);
    end
    advance(0);
    chk("c123_done", count, 30);
    advance(1);   chk("c124_count", count, 31); chk("c124_eq30", count_eq30, 0);

    // 2: count_g_100 at 101, clear restarts, first tick 4 clks later
    advance(276); chk("c400_count", count, 100); chk("c400_eq100", count_eq100, 1);
    advance(3);   chk("c403_g100", count_g_100, 0);
    advance(1);   chk("c404_count", count, 101); chk("c404_g100", count_g_100, 1);
    chk("c404_eq100", count_eq100, 0);
    clear_drv = 1'b1; advance(1); clear_drv = 1'b0;
    chk("clr_count", count, 0); chk("clr_g100", count_g_100, 0);
    advance(3);   chk("clr_p3_count", count, 0);
    advance(1);   chk("clr_p4_count", count, 1);

    // 3: hold at presc=2 count=45, resume two clks after release
    advance(176); chk("h_count45", count, 45);
    advance(2);   chk("h_pre_count", count, 45);
    hold = 1'b1; advance(10); chk("h_frozen", count, 45);
    hold = 1'b0;
    advance(1);   chk("h_rel1", count, 45);
    advance(1);   chk("h_rel2", count, 46);

    // 4: clear coincident with the tick at 89
    advance(172); chk("t4_count89", count, 89);
    advance(3);   chk("t4_pre", count, 89); chk("t4_eq90_pre", count_eq90, 0);
    clear_drv = 1'b1; advance(1); clear_drv = 1'b0;
    chk("t4_count", count, 0); chk("t4_eq90", count_eq90, 0);

    // 5: saturation and sticky timeout, cleared by clear even with hold
    advance(1019); chk("s_254", count, 254); chk("s_254_to", timeout, 0);
    advance(1);    chk("s_255", count, 255); chk("s_255_to", timeout, 1);
    chk("s_255_g100", count_g_100, 1);
    advance(8);    chk("s_stay", count, 255); chk("s_stay_to", timeout, 1);
    clear_drv = 1'b1; hold = 1'b1; advance(1); clear_drv = 1'b0;
    chk("s_clr_count", count, 0); chk("s_clr_to", timeout, 0);
    advance(1);    chk("s_hold_count", count, 0);
    hold = 1'b0;

    // 6: asynchronous reset mid-count while held
    advance(308); chk("r_count77", count, 77);
    hold = 1'b1; advance(2);
    #2 reset = 1'b0;
    #1;
    chk("r_async_count", count, 0);
    chk("r_async_flags", {count_eq30, count_eq90, count_eq100, count_g_100}, 0);
    chk("r_async_to", timeout, 0);
    @(posedge clk); #1;
    reset = 1'b1; hold = 1'b0;
    advance(3); chk("r_rel3", count, 0);
    advance(1); chk("r_rel4", count, 1);

    // 7: closed loop, four sides of 405 clks each
    clear_drv = 1'b1; advance(1); clear_drv = 1'b0; loop_en = 1'b1;
    chk("l_start", count, 0);
    advance(120); chk("l_red30", ctl_st, CTL_RED); chk("l_c30", count, 30);
    advance(1);   chk("l_green", ctl_st, CTL_GREEN);
    advance(240); chk("l_yellow", ctl_st, CTL_YELLOW); chk("l_c90", count, 90);
    advance(40);  chk("l_red", ctl_st, CTL_RED); chk("l_c100", count, 100);
    advance(4);   chk("l_wrap_count", count, 0); chk("l_side1", side, 1);
    advance(405 * 3);
    chk("l_side0", side, 0); chk("l_rot", rotations, 4);
    chk("l_end_state", ctl_st, CTL_RED); chk("l_timeout", timeout, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
